// File: rtl/dw3_22_if.sv
// dw3_22_if: request/result bundle between a requester and the w3_22 delta-weight generator
// start/delta/act flow master->slave; busy/dw/dw_valid flow slave->master.
interface dw3_22_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] act;
    logic             busy;
    logic [WIDTH-1:0] dw;
    logic             dw_valid;
    modport master (output start, delta, act, input busy, dw, dw_valid);
    modport slave (input start, delta, act, output busy, dw, dw_valid);
endinterface

// File: rtl/dw3_22_gen.sv
// dw3_22_gen: computes dw = -(ETA * delta * act) for w3_22 using a sequential shift-add multiplier
// Ports: clk, reset (async, active-high); bus.slave carries start, delta, act in and busy, dw, dw_valid out.
// The result lands 33 edges after the accepting edge; dw holds between results.
module dw3_22_gen #(
    parameter int WIDTH = 16,
    parameter int FRAC = 10,
    parameter logic signed [WIDTH-1:0] ETA = 16'sb00_0000_0100_0000_00
) (
    input logic clk,
    input logic reset,
    dw3_22_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ETA_MAG = ETA[WIDTH-1] ? WIDTH'(-ETA) : WIDTH'(ETA);
    typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, OUT} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] dw_q, dw_d;
    logic             dw_valid_q, dw_valid_d;
    logic [W2-1:0]    prod, shifted, lim;
    logic [WIDTH-1:0] mag;
    // Magnitude as unsigned WIDTH bits, so the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction
    // Datapath works on magnitudes; the limit is 2^(WIDTH-1) for a negative result, one less otherwise,
    // so the stored magnitude plus sign_q always describes a saturated signed value.
    always_comb begin
        prod = acc_q + (mplier_q[0] ? (W2'(mcand_q) << cnt_q) : '0);
        shifted = prod >> FRAC;
        lim = sign_q ? (W2'(1) << (WIDTH - 1)) : (W2'(1) << (WIDTH - 1)) - W2'(1);
        mag = shifted > lim ? lim[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        mcand_d = mcand_q;
        mplier_d = mplier_q;
        acc_d = acc_q;
        sign_d = sign_q;
        dw_d = dw_q;
        dw_valid_d = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                mcand_d = mag_of(bus.delta);
                mplier_d = mag_of(bus.act);
                sign_d = bus.delta[WIDTH-1] ^ bus.act[WIDTH-1];
                acc_d = '0;
                cnt_d = '0;
                state_d = MUL_A;
            end
            MUL_A, MUL_B: begin
                acc_d = prod;
                mplier_d = mplier_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    acc_d = '0;
                    mcand_d = mag;
                    if (state_q == MUL_A) begin
                        mplier_d = ETA_MAG;
                        sign_d = sign_q ^ ETA[WIDTH-1];
                        state_d = MUL_B;
                    end else begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                // Negating p2: a negative p2 of full magnitude clips to the positive maximum.
                dw_d = sign_q ? (mcand_q[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : mcand_q) : -mcand_q;
                dw_valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            mcand_q <= '0;
            mplier_q <= '0;
            acc_q <= '0;
            sign_q <= 1'b0;
            dw_q <= '0;
            dw_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            acc_q <= acc_d;
            sign_q <= sign_d;
            dw_q <= dw_d;
            dw_valid_q <= dw_valid_d;
        end
    end
    assign bus.busy = state_q != IDLE;
    assign bus.dw = dw_q;
    assign bus.dw_valid = dw_valid_q;
endmodule

// File: tb/tb_dw3_22_gen.sv
// tb_dw3_22_gen: table vectors, corner sequences and random operands checked against an arithmetic model
module tb_dw3_22_gen;
    localparam logic signed [15:0] ETA = 16'sh0100;
    typedef struct {
        logic [15:0] delta;
        logic [15:0] act;
        logic [15:0] exp;
        string       name;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    dw3_22_if #(.WIDTH(16)) bus();
    dw3_22_gen dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask
    function automatic longint sat16(input longint v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
    endfunction
    // Product of real values, truncated toward zero by integer division, clipped to 16 bits.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] a);
        longint p1, p2;
        p1 = sat16((longint'($signed(d)) * longint'($signed(a))) / 1024);
        p2 = sat16((p1 * longint'(ETA)) / 1024);
        return 16'(sat16(-p2));
    endfunction
    task automatic do_op(input logic [15:0] d, input logic [15:0] a, input logic [15:0] expv,
                         input int restart_at, input string name);
        int n, nb;
        @(negedge clk);
        bus.start = 1'b1;
        bus.delta = d;
        bus.act = a;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.delta = 16'($urandom);
        bus.act = 16'($urandom);
        n = 0;
        nb = 0;
        while (!bus.dw_valid && n < 40) begin
            nb += int'(bus.busy);
            bus.start = (n == restart_at);
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        check({name, "_latency"}, 32'(n), 32'd33);
        check({name, "_busy_cycles"}, 32'(nb), 32'd33);
        check({name, "_busy_end"}, 32'(bus.busy), 32'd0);
        check({name, "_dw"}, 32'(bus.dw), 32'(expv));
        @(posedge clk);
        #1;
        check({name, "_valid_one_cycle"}, 32'(bus.dw_valid), 32'd0);
        check({name, "_dw_hold"}, 32'(bus.dw), 32'(expv));
    endtask
    task automatic expect_quiet(input int cycles, input logic [15:0] dw_exp, input string name);
        int nv = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            nv += int'(bus.dw_valid);
        end
        check({name, "_no_extra_valid"}, 32'(nv), 32'd0);
        check({name, "_dw_unchanged"}, 32'(bus.dw), 32'(dw_exp));
    endtask
    vec_t vecs[$];
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [15:0] d, a;
        bus.start = 1'b0;
        bus.delta = '0;
        bus.act = '0;
        vecs.push_back('{16'h0200, 16'h0200, 16'hFFC0, "nominal"});
        vecs.push_back('{16'hFC00, 16'h0200, 16'h0080, "sign"});
        vecs.push_back('{16'hFFFD, 16'h0200, 16'h0000, "trunc"});
        vecs.push_back('{16'h7C00, 16'h7C00, 16'hE001, "sat"});
        vecs.push_back('{16'h0000, 16'h1234, 16'h0000, "zero"});
        vecs.push_back('{16'h8000, 16'h0400, 16'h2000, "minneg"});
        vecs.push_back('{16'h8000, 16'h8000, 16'hE001, "minsq"});
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_dw", 32'(bus.dw), 32'd0);
        check("reset_valid", 32'(bus.dw_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        foreach (vecs[i]) do_op(vecs[i].delta, vecs[i].act, vecs[i].exp, -1, vecs[i].name);
        do_op(16'h0200, 16'h0200, 16'hFFC0, 8, "restart_mid");
        expect_quiet(40, 16'hFFC0, "restart_mid");
        do_op(16'hFC00, 16'h0200, 16'h0080, 32, "restart_at_out");
        expect_quiet(40, 16'h0080, "restart_at_out");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_dw", 32'(bus.dw), 32'd0);
        check("async_reset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op(16'h0200, 16'h0200, 16'hFFC0, -1, "pre_abort");
        @(negedge clk);
        bus.start = 1'b1;
        bus.delta = 16'hFC00;
        bus.act = 16'h0200;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_dw", 32'(bus.dw), 32'd0);
        check("abort_valid", 32'(bus.dw_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        expect_quiet(40, 16'h0000, "abort");
        do_op(16'hFC00, 16'h0200, 16'h0080, -1, "after_abort");
        for (int i = 0; i < 24; i++) begin
            d = 16'($urandom);
            a = 16'($urandom);
            if (i % 2 == 1) begin
                d = {{5{d[10]}}, d[10:0]};
                a = {{5{a[10]}}, a[10:0]};
            end
            do_op(d, a, model(d, a), (i % 3 == 0) ? int'($urandom_range(0, 32)) : -1, $sformatf("rand%0d", i));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
